regfile_onehot: RTL and testbench
=================================

# regfile_onehot

Eight-entry general-purpose register file for the LC-3b datapath, written through a one-hot load vector driven directly by the 3-to-8 destination decoder stage. It sits downstream of that decoder: the decoder turns the destination register number plus the load enable into `load_sel`, and this block stores the writeback value, serves two combinational read ports with write-through bypass, and flags any malformed (multi-hot) load vector.

## Interface
- `WIDTH`, default 16, data width of every register and data port.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `load_sel`  input  8  one-hot write select from the decoder; bit i set means write register i; all-zero means no write.
- `in`  input  WIDTH  writeback data.
- `src_a`  input  3  read port A register index.
- `src_b`  input  3  read port B register index.
- `clear_err`  input  1  synchronous clear of `onehot_err` and `err_count`.
- `reg_a`  output  WIDTH  read port A data.
- `reg_b`  output  WIDTH  read port B data.
- `onehot_err`  output  1  sticky flag: a multi-hot `load_sel` was seen.
- `err_count`  output  4  saturating count of multi-hot cycles since reset or clear.

## Operation
- State: `r[0..7]` (WIDTH bits each), `onehot_err`, `err_count`.
- Classify `load_sel` each cycle, combinationally:
  - none: all bits 0.
  - valid: exactly one bit set, index k.
  - multi: two or more bits set.
- Rising edge of `clk`, `reset` low:
  - valid: `r[k] <= in`; all other registers hold.
  - none: all registers hold.
  - multi: all registers hold (no partial write); `onehot_err <= 1`; `err_count <= min(err_count+1, 15)`.
- `clear_err` high at an edge: `onehot_err` and `err_count` clear. Same-edge multi event: the clear applies first, then the event is counted, giving `onehot_err=1`, `err_count=1`.
- `err_count` saturates at 15 and never wraps. `onehot_err` remains 1 until reset or clear.
- Read ports are combinational:
  - `reg_a = (valid && k==src_a) ? in : r[src_a]`.
  - `reg_b` follows the same rule with `src_b`.
  - Bypass is active only for a valid one-hot; none or multi never bypasses.
  - Both ports may address the same register, and both may bypass in the same cycle.
- All registers, including r0, are writable. There is no hardwired zero.

## Timing
- `reset` asserted (asynchronous, any time):
  - Immediately: all `r[i]=0`, `onehot_err=0`, `err_count=0`, so `reg_a`/`reg_b` read 0 unless bypassing.
  - While `reset` is high, edges cause no writes. A write coincident with `reset` is lost.
- `reset` deassertion: the first rising edge with `reset` low performs normal updates.
- Write latency:
  - Value is visible on a read port in the same cycle through the bypass.
  - Value is visible from the array from the cycle after the edge onward.
- `onehot_err` and `err_count` update at the edge that ends the multi cycle and are visible the following cycle.
- Read outputs depend only on current inputs and state: zero-cycle combinational path from `src_*`, `load_sel`, `in`.
- No handshake. One write at most per cycle. Reads are unlimited.

## Test plan
- Reset, then write: assert `reset`, release, drive `load_sel=8'b0000_1000`, `in=16'hBEEF` for one edge, then `src_a=3` -> `reg_a=16'hBEEF` in the write cycle (bypass) and after it; every other register reads 0.
- Fill and readback: write `16'h1000+i` to each register i (`load_sel=1<<i`), then sweep `src_a`/`src_b` over 0..7 -> both ports return `16'h1000+i`; a no-write cycle (`load_sel=0`, `in=16'hFFFF`) changes nothing and never bypasses.
- Multi-hot rejection: with r2=`16'h0002` and r5=`16'h0005`, drive `load_sel=8'b0010_0100`, `in=16'hDEAD` -> r2 and r5 unchanged, no bypass on `src_a=2`, `onehot_err=1`, `err_count=1` next cycle.
- Saturation and clear: hold a multi-hot value for 20 edges -> `err_count` stops at 15. Then assert `clear_err` for one edge while a multi-hot value is present -> `onehot_err=1`, `err_count=1`. A further clear with a valid `load_sel` -> both read 0.
- Async reset mid-operation: write r7=`16'h7777`, then pulse `reset` between clock edges -> `reg_a` (`src_a=7`) drops to 0 before the next edge, and `err_count` reads 0.

Source files
------------

// File: rtl/regfile_onehot.sv
// Eight-entry register file written through a one-hot load vector, with two
// combinational read ports, write-through bypass and multi-hot load detection.
module regfile_onehot #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       load_sel,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       src_a,
    input  logic [2:0]       src_b,
    input  logic             clear_err,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_b,
    output logic             onehot_err,
    output logic [3:0]       err_count
);

    logic [WIDTH-1:0] regs_q [8];
    logic [WIDTH-1:0] regs_d [8];
    logic             onehot_err_q, onehot_err_d;
    logic [3:0]       err_count_q, err_count_d;

    logic             sel_none;
    logic             sel_multi;
    logic             sel_valid;
    logic [2:0]       sel_idx;
    logic [3:0]       cnt_base;

    // Clearing the lowest set bit leaves a nonzero value only for multi-hot.
    assign sel_none  = (load_sel == 8'd0);
    assign sel_multi = ((load_sel & (load_sel - 8'd1)) != 8'd0);
    assign sel_valid = !sel_none && !sel_multi;

    always_comb begin
        sel_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (load_sel[i]) begin
                sel_idx = 3'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (sel_valid) begin
            regs_d[sel_idx] = in;
        end
    end

    // Clear takes effect first so a same-edge multi-hot event is still counted.
    always_comb begin
        cnt_base     = clear_err ? 4'd0 : err_count_q;
        onehot_err_d = clear_err ? 1'b0 : onehot_err_q;
        err_count_d  = cnt_base;
        if (sel_multi) begin
            onehot_err_d = 1'b1;
            err_count_d  = (cnt_base == 4'd15) ? 4'd15 : cnt_base + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
            onehot_err_q <= 1'b0;
            err_count_q  <= 4'd0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
            onehot_err_q <= onehot_err_d;
            err_count_q  <= err_count_d;
        end
    end

    always_comb begin
        reg_a = regs_q[src_a];
        reg_b = regs_q[src_b];
        if (sel_valid && (sel_idx == src_a)) begin
            reg_a = in;
        end
        if (sel_valid && (sel_idx == src_b)) begin
            reg_b = in;
        end
    end

    assign onehot_err = onehot_err_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_regfile_onehot.sv
// Directed bench for regfile_onehot: behavioural model checked every negedge,
// plus hand-computed literal checks for each scenario.
module tb_regfile_onehot;

    logic        clk;
    logic        reset;
    logic [7:0]  load_sel;
    logic [15:0] in;
    logic [2:0]  src_a;
    logic [2:0]  src_b;
    logic        clear_err;
    logic [15:0] reg_a;
    logic [15:0] reg_b;
    logic        onehot_err;
    logic [3:0]  err_count;

    int total;
    int bad;

    // Model state
    logic [15:0] m_r [8];
    logic        m_err;
    int          m_cnt;

    regfile_onehot #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .load_sel  (load_sel),
        .in        (in),
        .src_a     (src_a),
        .src_b     (src_b),
        .clear_err (clear_err),
        .reg_a     (reg_a),
        .reg_b     (reg_b),
        .onehot_err(onehot_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [2:0] idx);
        if ($countones(load_sel) == 1 && load_sel[idx]) return in;
        return m_r[idx];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            if (clear_err) begin
                m_err = 1'b0;
                m_cnt = 0;
            end
            if ($countones(load_sel) == 1) begin
                for (int i = 0; i < 8; i++) if (load_sel[i]) m_r[i] = in;
            end else if ($countones(load_sel) > 1) begin
                m_err = 1'b1;
                if (m_cnt < 15) m_cnt = m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("model reg_a", {16'h0, reg_a}, {16'h0, model_read(src_a)});
            chk("model reg_b", {16'h0, reg_b}, {16'h0, model_read(src_b)});
            chk("model onehot_err", {31'h0, onehot_err}, {31'h0, m_err});
            chk("model err_count", {28'h0, err_count}, 32'(m_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] sel, input logic [15:0] d,
                         input logic [2:0] a, input logic [2:0] b, input logic clr);
        load_sel  = sel;
        in        = d;
        src_a     = a;
        src_b     = b;
        clear_err = clr;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        load_sel = 8'h0; in = 16'h0; src_a = 3'd0; src_b = 3'd0; clear_err = 1'b0;
        #1;
        chk("reset reg_a", {16'h0, reg_a}, 32'h0);
        chk("reset err_count", {28'h0, err_count}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset then write r3
        drive(8'b0000_1000, 16'hBEEF, 3'd3, 3'd0, 1'b0);
        chk("bypass r3", {16'h0, reg_a}, 32'hBEEF);
        chk("r0 zero", {16'h0, reg_b}, 32'h0);
        step();
        drive(8'h00, 16'h0000, 3'd3, 3'd0, 1'b0);
        chk("array r3", {16'h0, reg_a}, 32'hBEEF);
        for (int i = 0; i < 8; i++) begin
            if (i != 3) begin
                drive(8'h00, 16'h0000, 3'd3, 3'(i), 1'b0);
                chk("other zero", {16'h0, reg_b}, 32'h0);
            end
        end

        // Fill and readback
        for (int i = 0; i < 8; i++) begin
            drive(8'(1 << i), 16'h1000 + 16'(i), 3'(i), 3'(7 - i), 1'b0);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            drive(8'h00, 16'hFFFF, 3'(i), 3'(7 - i), 1'b0);
            chk("fill a", {16'h0, reg_a}, 32'h1000 + 32'(i));
            chk("fill b", {16'h0, reg_b}, 32'h1000 + 32'(7 - i));
        end
        step();
        chk("no write hold", {16'h0, reg_a}, 32'h1007);

        // Multi-hot rejection
        drive(8'b0000_0100, 16'h0002, 3'd0, 3'd0, 1'b0); step();
        drive(8'b0010_0000, 16'h0005, 3'd0, 3'd0, 1'b0); step();
        drive(8'b0010_0100, 16'hDEAD, 3'd2, 3'd5, 1'b0);
        chk("multi no bypass a", {16'h0, reg_a}, 32'h0002);
        chk("multi no bypass b", {16'h0, reg_b}, 32'h0005);
        step();
        drive(8'h00, 16'h0000, 3'd2, 3'd5, 1'b0);
        chk("multi r2 kept", {16'h0, reg_a}, 32'h0002);
        chk("multi r5 kept", {16'h0, reg_b}, 32'h0005);
        chk("multi err", {31'h0, onehot_err}, 32'h1);
        chk("multi count", {28'h0, err_count}, 32'h1);

        // Saturation and clear
        drive(8'b1100_0000, 16'h1234, 3'd6, 3'd7, 1'b0);
        repeat (20) step();
        chk("saturate", {28'h0, err_count}, 32'd15);
        drive(8'b1100_0000, 16'h1234, 3'd6, 3'd7, 1'b1);
        step();
        drive(8'h00, 16'h0000, 3'd6, 3'd7, 1'b0);
        chk("clear+multi err", {31'h0, onehot_err}, 32'h1);
        chk("clear+multi count", {28'h0, err_count}, 32'h1);
        drive(8'h01, 16'h00AA, 3'd0, 3'd1, 1'b1);
        step();
        drive(8'h00, 16'h0000, 3'd0, 3'd1, 1'b0);
        chk("clear err", {31'h0, onehot_err}, 32'h0);
        chk("clear count", {28'h0, err_count}, 32'h0);
        chk("clear cycle write", {16'h0, reg_a}, 32'h00AA);

        // Async reset mid-operation
        drive(8'h03, 16'h0000, 3'd0, 3'd0, 1'b0); step();
        drive(8'h80, 16'h7777, 3'd7, 3'd7, 1'b0); step();
        drive(8'h00, 16'h0000, 3'd7, 3'd0, 1'b0);
        chk("r7 written", {16'h0, reg_a}, 32'h7777);
        chk("pre-reset count", {28'h0, err_count}, 32'h1);
        reset = 1'b1;
        #1;
        chk("async reg_a", {16'h0, reg_a}, 32'h0);
        chk("async count", {28'h0, err_count}, 32'h0);
        chk("async err", {31'h0, onehot_err}, 32'h0);
        #1;
        reset = 1'b0;
        step();
        chk("post reset r7", {16'h0, reg_a}, 32'h0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
